// File: rtl/dff_checker.sv
// rtl/dff_checker.sv - golden-delay response monitor for flip-flop designs under test
module dff_checker #(
   parameter int LAT  = 1,
   parameter int CNTW = 16
) (
   input  logic            C,
   input  logic            Rn,
   input  logic            start,
   input  logic            stop,
   input  logic            D,
   input  logic            Q,
   input  logic            Qn,
   output logic            busy,
   output logic            done,
   output logic            err,
   output logic [CNTW-1:0] chk_cnt,
   output logic [CNTW-1:0] mism_cnt,
   output logic [CNTW-1:0] fail_idx
);

   typedef enum logic [1:0] {IDLE, FILL, CHECK, DONE} state_t;

   localparam logic [3:0]      LAT_W = 4'(LAT);
   localparam logic [CNTW-1:0] CMAX  = '1;

   state_t          state, state_nxt;
   logic [LAT-1:0]  pipe;
   logic [3:0]      fill_cnt;
   logic [3:0]      fill_inc;
   logic            exp_q;
   logic            mism;
   logic            shift_en;
   logic            load;
   logic            cmp_en;

   // Expected Q is D delayed by LAT edges; a broken complement is a failure on its own.
   assign exp_q    = pipe[LAT-1];
   assign mism     = (Q != exp_q) || (Qn == Q);
   assign fill_inc = fill_cnt + 4'd1;

   // State register.
   always_ff @(posedge C or negedge Rn) begin
      if (!Rn) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state, pipeline/compare enables and status outputs.
   always_comb begin
      state_nxt = state;
      shift_en  = 1'b0;
      load      = 1'b0;
      cmp_en    = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load      = 1'b1;
               shift_en  = 1'b1;
               state_nxt = (LAT == 1) ? CHECK : FILL;
            end
         end
         FILL: begin
            busy     = 1'b1;
            shift_en = 1'b1;
            if (stop)                   state_nxt = DONE;
            else if (fill_inc == LAT_W) state_nxt = CHECK;
         end
         CHECK: begin
            busy     = 1'b1;
            shift_en = 1'b1;
            cmp_en   = 1'b1;
            if (stop) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Golden delay line of the D stimulus.
   always_ff @(posedge C or negedge Rn) begin
      if (!Rn) begin
         pipe <= '0;
      end else if (shift_en) begin
         pipe[0] <= D;
         for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      end
   end

   // Counts pipeline stages filled since start; decides when compares may begin.
   always_ff @(posedge C or negedge Rn) begin
      if (!Rn)                fill_cnt <= 4'd0;
      else if (load)          fill_cnt <= 4'd1;
      else if (state == FILL) fill_cnt <= fill_inc;
   end

   // Saturating check/mismatch counters and first-failure capture.
   always_ff @(posedge C or negedge Rn) begin
      if (!Rn) begin
         chk_cnt  <= '0;
         mism_cnt <= '0;
         fail_idx <= '0;
         err      <= 1'b0;
      end else if (load) begin
         chk_cnt  <= '0;
         mism_cnt <= '0;
         fail_idx <= '0;
         err      <= 1'b0;
      end else if (cmp_en) begin
         if (chk_cnt != CMAX) chk_cnt <= chk_cnt + 1'b1;
         if (mism) begin
            if (mism_cnt != CMAX) mism_cnt <= mism_cnt + 1'b1;
            if (!err) begin
               err      <= 1'b1;
               fail_idx <= chk_cnt;
            end
         end
      end
   end

endmodule

// File: doc/dff_checker.md
# dff_checker

Self-checking response monitor for the flip-flop designs (behavioural, SR-based, master-slave). It sits on the observe side of a flip-flop under test: it taps the same D stimulus applied to the DUT and compares the DUT's Q/Qn against a golden delayed copy of D. It counts checks and mismatches and latches the index of the first failure, so pass/fail is read from registers instead of from a waveform.

## Interface
Parameters:
- LAT, 1: DUT latency in clock cycles from D sampled to Q valid; legal range 1..8.
- CNTW, 16: width of all counters and the failure index.

Ports:
- C  in  1  clock; all sampling on posedge.
- Rn  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request to begin a check run; clears the counters.
- stop  in  1  one-cycle request to end the run.
- D  in  1  stimulus exactly as applied to the DUT's D input.
- Q  in  1  DUT true output.
- Qn  in  1  DUT complement output.
- busy  out  1  high in FILL and CHECK.
- done  out  1  one-cycle pulse when a run ends.
- err  out  1  sticky flag: at least one mismatch this run.
- chk_cnt  out  CNTW  number of compares performed this run.
- mism_cnt  out  CNTW  number of failed compares this run.
- fail_idx  out  CNTW  chk_cnt value at the first mismatch (0-based); valid only when err=1.

## Operation
- Expected pipeline: shift register pipe[0..LAT-1] of D. On every posedge in FILL and CHECK, and on the accepting start edge, pipe[0]<=D and pipe[i]<=pipe[i-1]. The expected value is exp = pipe[LAT-1].
- A compare fails if Q != exp or Qn != ~Q. Either condition alone counts as one mismatch per cycle, not two.
- States:
  - IDLE: outputs hold their last run's values. start=1 loads pipe[0], sets fill count to 1, clears chk_cnt, mism_cnt, fail_idx and err, then moves to CHECK if LAT==1, else to FILL.
  - FILL: shifts only, with no compares. Moves to CHECK on the edge where the fill count reaches LAT, so FILL lasts LAT-1 cycles.
  - CHECK: each edge performs one compare and increments chk_cnt. On a mismatch it increments mism_cnt; if err was 0, it sets err and writes fail_idx with the pre-increment chk_cnt.
  - DONE: done=1 for exactly one cycle, then IDLE.
- stop in FILL or CHECK moves to DONE on the next edge. A stop sampled in CHECK still performs that edge's compare; in FILL, no compare is performed.
- start while not in IDLE is ignored. stop in IDLE or DONE is ignored. If start and stop are both high in IDLE, start is taken and stop is ignored.
- Counters saturate at 2^CNTW-1 and never wrap. err stays set even after mism_cnt saturates.
- A saturated chk_cnt is still a valid fail_idx value.

## Timing
- Reset (Rn=0, asynchronous): state=IDLE, pipe=0, fill count=0, busy=0, done=0, err=0, chk_cnt=0, mism_cnt=0, fail_idx=0. Reset overrides any run in progress, and no done pulse is produced.
- D sampled at the start edge k is compared against Q/Qn sampled at edge k+LAT. That edge is the first compare.
- busy rises the cycle after the start edge and falls the cycle after the stop edge.
- done is high for the single cycle after the stop edge.
- err, mism_cnt and fail_idx update on the same edge as the failing compare and are visible in the following cycle.
- Deassertion of Rn is synchronous to C on the input side: the first active edge is the first posedge with Rn=1.

## Test plan
- Ideal DFF model, LAT=1. D=0 for 8 cycles, 1 for 8, 0 for 8, 1 for 8; start at cycle 0, stop at cycle 24. Required: chk_cnt=24, mism_cnt=0, err=0, and one done pulse at cycle 25.
- Same setup, with Q forced inverted only on compare index 5. Required: err=1, fail_idx=5, mism_cnt=1, chk_cnt=24.
- Qn tied to Q (broken complement) for compares 10..12, with Q correct throughout. Required: mism_cnt=3, fail_idx=10.
- LAT=3 with a 3-stage delay model and D alternating every cycle. Required: busy rises after start; the first compare occurs at start edge +3; the run ends with mism_cnt=0. Rerun with a 2-stage model: every compare fails.
- Rn pulsed low mid-CHECK after 7 compares with 2 mismatches. Required: all outputs return to 0 immediately, no done pulse, and a following start runs normally.
- CNTW=4 with Q stuck at 1 and D=0 for 20 compares. Required: chk_cnt=15, mism_cnt=15 (both saturated, no wrap), fail_idx=0. Also: start pulsed while busy changes nothing, and start together with stop in IDLE begins a run.
